// File: rtl/minterm_pkg.sv
// minterm_pkg: shared FSM encoding and truth-table mask addressing for minterm sweeps
package minterm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   // bit position of channel c, minterm m inside a packed N_FN*2^n_in mask
   function automatic int unsigned mask_off(input int unsigned c, input int unsigned m,
                                            input int unsigned n_in);
      return c * (32'd1 << n_in) + m;
   endfunction

endpackage

// File: rtl/minterm_mux.sv
// minterm_mux: picks each channel's expected output for the selected minterm
module minterm_mux
   import minterm_pkg::*;
#(
   parameter int N_IN = 4,
   parameter int N_FN = 5
) (
   input  logic [N_FN*(1<<N_IN)-1:0] mask,
   input  logic [N_IN-1:0]           sel,
   output logic [N_FN-1:0]           exp_o
);

   localparam int M = 1 << N_IN;

   for (genvar c = 0; c < N_FN; c++) begin : g_ch
      logic [M-1:0] tt;
      assign tt       = mask[mask_off(c, 0, N_IN) +: M];
      assign exp_o[c] = tt[sel];
   end

endmodule

// File: rtl/minterm_sweep_checker.sv
// minterm_sweep_checker: exhaustive truth-table sweep comparing N_FN function outputs against latched masks
module minterm_sweep_checker
   import minterm_pkg::*;
#(
   parameter int N_IN = 4,
   parameter int N_FN = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [N_FN*(1<<N_IN)-1:0] mask,
   input  logic [N_FN-1:0]           resp,
   output logic [N_IN-1:0]           stim,
   output logic                      busy,
   output logic                      done,
   output logic [N_FN-1:0]           err_ch,
   output logic [N_IN:0]             err_cnt,
   output logic [N_IN-1:0]           first_err,
   output logic                      first_vld
);

   localparam int MW = N_FN * (1 << N_IN);

   state_t          state_q, state_d;
   logic [N_IN-1:0] stim_q, stim_d;
   logic [MW-1:0]   mask_q, mask_d;
   logic [N_FN-1:0] err_ch_q, err_ch_d;
   logic [N_IN:0]   err_cnt_q, err_cnt_d;
   logic [N_IN-1:0] first_err_q, first_err_d;
   logic            first_vld_q, first_vld_d;
   logic [N_FN-1:0] exp_w, mis_w;

   minterm_mux #(.N_IN(N_IN), .N_FN(N_FN)) u_mux (
      .mask  (mask_q),
      .sel   (stim_q),
      .exp_o (exp_w)
   );

   assign mis_w = resp ^ exp_w;

   // next state: latch mask on start, accumulate mismatches while sweeping
   always_comb begin
      state_d     = state_q;
      stim_d      = stim_q;
      mask_d      = mask_q;
      err_ch_d    = err_ch_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
      first_vld_d = first_vld_q;
      unique case (state_q)
         IDLE: begin
            stim_d = '0;
            if (start) begin
               state_d     = SWEEP;
               mask_d      = mask;
               err_ch_d    = '0;
               err_cnt_d   = '0;
               first_err_d = '0;
               first_vld_d = 1'b0;
            end
         end
         SWEEP: begin
            if (|mis_w) begin
               err_cnt_d   = err_cnt_q + (N_IN+1)'(1);
               err_ch_d    = err_ch_q | mis_w;
               first_err_d = first_vld_q ? first_err_q : stim_q;
               first_vld_d = 1'b1;
            end
            state_d = &stim_q ? DONE : SWEEP;
            stim_d  = &stim_q ? '0 : stim_q + N_IN'(1);
         end
         DONE: begin
            state_d = IDLE;
            stim_d  = '0;
         end
         default: begin
            state_d = IDLE;
            stim_d  = '0;
         end
      endcase
   end

   // state and result registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         stim_q      <= '0;
         mask_q      <= '0;
         err_ch_q    <= '0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
         first_vld_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         stim_q      <= stim_d;
         mask_q      <= mask_d;
         err_ch_q    <= err_ch_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
         first_vld_q <= first_vld_d;
      end
   end

   assign stim      = stim_q;
   assign busy      = state_q == SWEEP;
   assign done      = state_q == DONE;
   assign err_ch    = err_ch_q;
   assign err_cnt   = err_cnt_q;
   assign first_err = first_err_q;
   assign first_vld = first_vld_q;

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// tb_minterm_sweep_checker: scoreboard bench driving truth-table functions against random and directed masks
module tb_minterm_sweep_checker;

   localparam int N_IN = 4;
   localparam int N_FN = 5;
   localparam int M    = 1 << N_IN;

   typedef struct {
      logic [N_FN-1:0] ch;
      logic [N_IN:0]   cnt;
      logic [N_IN-1:0] fe;
      logic            fv;
      int              cyc;
   } exp_t;

   logic                clk = 0;
   logic                reset = 1;
   logic                start = 0;
   logic [N_FN*M-1:0]   mask = '0;
   logic [N_FN-1:0]     resp;
   logic [N_IN-1:0]     stim;
   logic                busy, done, first_vld;
   logic [N_FN-1:0]     err_ch;
   logic [N_IN:0]       err_cnt;
   logic [N_IN-1:0]     first_err;

   logic [M-1:0]        fn_tt [N_FN];
   exp_t                q[$];
   exp_t                last;
   int                  cyc = 0;
   int                  n_chk = 0;
   int                  n_fail = 0;

   minterm_sweep_checker #(.N_IN(N_IN), .N_FN(N_FN)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .mask      (mask),
      .resp      (resp),
      .stim      (stim),
      .busy      (busy),
      .done      (done),
      .err_ch    (err_ch),
      .err_cnt   (err_cnt),
      .first_err (first_err),
      .first_vld (first_vld)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // the function under verification: each channel is a plain truth table indexed by stim
   always_comb for (int c = 0; c < N_FN; c++) resp[c] = fn_tt[c][stim];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic logic [N_FN*M-1:0] pack_tt();
      logic [N_FN*M-1:0] r;
      for (int c = 0; c < N_FN; c++) r[c*M +: M] = fn_tt[c];
      return r;
   endfunction

   // reference: walk every minterm, compare function table against mask table
   function automatic exp_t model(input logic [N_FN*M-1:0] mk, input int sc);
      exp_t e;
      logic [N_FN-1:0] bad;
      e.ch = '0; e.cnt = '0; e.fe = '0; e.fv = 1'b0; e.cyc = sc + M + 1;
      for (int m = 0; m < M; m++) begin
         for (int c = 0; c < N_FN; c++) bad[c] = fn_tt[c][m] != mk[c*M + m];
         if (bad != 0) begin
            e.ch  = e.ch | bad;
            e.cnt = e.cnt + 1;
            if (!e.fv) begin
               e.fe = N_IN'(m);
               e.fv = 1'b1;
            end
         end
      end
      return e;
   endfunction

   task automatic run(input logic [N_FN*M-1:0] mk);
      @(negedge clk);
      mask  = mk;
      start = 1;
      q.push_back(model(mk, cyc));
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
      chk("sweep_timeout", q.size(), 0);
      repeat (3) @(negedge clk);
      chk("hold_err_ch", err_ch, last.ch);
      chk("hold_err_cnt", err_cnt, last.cnt);
      chk("hold_first_vld", first_vld, last.fv);
   endtask

   // monitor: every done pulse pops one expectation
   always @(negedge clk) begin
      exp_t e;
      if (!reset) chk("busy_done_excl", busy && done, 0);
      if (done) begin
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1, expected no pulse (t=%0t)", $time);
         end else begin
            e = q.pop_front();
            last = e;
            chk("done_cycle", cyc, e.cyc);
            chk("err_ch", err_ch, e.ch);
            chk("err_cnt", err_cnt, e.cnt);
            chk("first_vld", first_vld, e.fv);
            if (e.fv) chk("first_err", first_err, e.fe);
         end
      end
   end

   initial begin
      logic [N_FN*M-1:0] mk;
      for (int c = 0; c < N_FN; c++) fn_tt[c] = '0;
      repeat (3) @(negedge clk);
      chk("rst_stim", stim, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err_ch", err_ch, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_first_err", first_err, 0);
      chk("rst_first_vld", first_vld, 0);
      reset = 0;
      // correct sum of minterms 1,3,6,7,11,15
      fn_tt[0] = 16'h88CA;
      run(pack_tt());
      wait_idle();
      chk("tp1_err_cnt", err_cnt, 0);
      chk("tp1_first_vld", first_vld, 0);
      // implementation missing minterm 11
      mk = pack_tt();
      fn_tt[0] = 16'h80CA;
      run(mk);
      wait_idle();
      chk("tp2_err_ch", err_ch, 5'b00001);
      chk("tp2_err_cnt", err_cnt, 1);
      chk("tp2_first_err", first_err, 11);
      // channel 1 mask 0,2,5,9,13 against a function true on all even minterms; extra start while busy
      fn_tt[0] = 16'h88CA;
      fn_tt[1] = 16'h5555;
      mk = pack_tt();
      mk[M +: M] = 16'h2225;
      run(mk);
      repeat (4) @(negedge clk);
      chk("busy_mid", busy, 1);
      start = 1;
      @(negedge clk);
      start = 0;
      wait_idle();
      chk("tp3_err_ch", err_ch, 5'b00010);
      chk("tp3_err_cnt", err_cnt, 9);
      chk("tp3_first_err", first_err, 4);
      repeat (20) @(negedge clk);
      // reset in the middle of a failing sweep
      run(mk);
      for (int i = 0; i < 40 && stim != 7; i++) @(negedge clk);
      chk("reach_stim7", stim, 7);
      void'(q.pop_back());
      reset = 1;
      @(negedge clk);
      reset = 0;
      chk("mrst_busy", busy, 0);
      chk("mrst_stim", stim, 0);
      chk("mrst_err_ch", err_ch, 0);
      chk("mrst_err_cnt", err_cnt, 0);
      chk("mrst_first_vld", first_vld, 0);
      repeat (20) @(negedge clk);
      run(mk);
      wait_idle();
      // mask altered right after start must not matter
      run(mk);
      mask = ~mk;
      wait_idle();
      chk("latched_err_cnt", err_cnt, 9);
      // random functions against masks with sparse random disagreements
      for (int t = 0; t < 20; t++) begin
         for (int c = 0; c < N_FN; c++) fn_tt[c] = M'($urandom);
         mk = pack_tt();
         for (int c = 0; c < N_FN; c++)
            if ($urandom_range(0, 2) != 0) mk[c*M +: M] ^= M'($urandom & $urandom & $urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run(mk);
         mask = {N_FN{M'($urandom)}};
         wait_idle();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
